pru1_cpu_oci_dct_packer: RTL

PRU1_CPU_OCI_DCT_PACKER -- requirements
Module: pru1_cpu_oci_dct_packer

---
 rtl/pru1_cpu_oci_dct_packer.sv | 119 +++++++++++
 1 files changed

// File: rtl/pru1_cpu_oci_dct_packer.sv
// Packs 2-bit trace compression codes into 30-bit words of 15 slots, with
// flush, drain-to-end and sticky overflow handling.
module pru1_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        tr_valid,
  input  logic [1:0]  tr_code,
  input  logic        flush_req,
  input  logic        test_ending,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, ENDED} state_t;

  localparam logic [3:0] LAST_SLOT = 4'd14;

  state_t      state;
  logic [29:0] acc;
  logic [3:0]  acc_cnt;

  logic        slot_free;
  logic        in_pack;
  logic        accept;
  logic        drop;
  logic        pack_emit;
  logic        drain_emit;
  logic        emit;
  logic [29:0] acc_ins;
  logic [29:0] emit_buf;
  logic [3:0]  emit_cnt;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    slot_free  = !word_valid || word_ready;
    in_pack    = (state == PACK);
    accept     = 1'b0;
    drop       = 1'b0;
    pack_emit  = 1'b0;
    drain_emit = 1'b0;
    // The code lands in slot acc_cnt; at slot 14 this is {tr_code, acc[27:0]}.
    acc_ins    = acc | ({28'b0, tr_code} << {acc_cnt, 1'b0});
    emit_buf   = acc;
    emit_cnt   = acc_cnt;

    if (in_pack && trc_on && tr_valid) begin
      if (acc_cnt < LAST_SLOT || slot_free) accept = 1'b1;
      else                                  drop   = 1'b1;
    end

    if (in_pack) begin
      pack_emit = (accept && acc_cnt == LAST_SLOT) ||
                  (flush_req && slot_free && (acc_cnt != 4'd0 || accept));
      if (accept) begin
        emit_buf = acc_ins;
        emit_cnt = acc_cnt + 4'd1;
      end
    end

    drain_emit = (state == DRAIN) && (acc_cnt != 4'd0) && slot_free;
    emit       = pack_emit || drain_emit;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      acc            <= '0;
      acc_cnt        <= '0;
      word_valid     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (state != ENDED) begin
        if (emit) begin
          word_valid <= 1'b1;
          dct_buffer <= emit_buf;
          dct_count  <= emit_cnt;
          acc        <= '0;
          acc_cnt    <= '0;
        end else begin
          if (word_valid && word_ready) word_valid <= 1'b0;
          if (accept) begin
            acc     <= acc_ins;
            acc_cnt <= acc_cnt + 4'd1;
          end
        end
        if (drop) overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (test_ending) state <= DRAIN;
          else if (trc_on) state <= PACK;
        end
        PACK: begin
          if (test_ending)  state <= DRAIN;
          else if (!trc_on) state <= IDLE;
        end
        DRAIN: begin
          // Done once the accumulator is empty and the last word has left.
          if (acc_cnt == 4'd0 && (!word_valid || word_ready)) begin
            state          <= ENDED;
            test_has_ended <= 1'b1;
          end
        end
        default: state <= ENDED;
      endcase
    end
  end

endmodule
